// File: rtl/seg_pkg.sv
// Segment glyph constants shared by the seven-segment scan driver and its decoder.
// Segment vectors are active-high, bit 0 = a through bit 6 = g.
package seg_pkg;

  localparam logic [3:0] CODE_DASH = 4'd10;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational 4-bit digit code to active-high a..g segment pattern.
// Codes 11-15 decode to an unlit glyph.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:      seg = SEG_0;
      4'd1:      seg = SEG_1;
      4'd2:      seg = SEG_2;
      4'd3:      seg = SEG_3;
      4'd4:      seg = SEG_4;
      4'd5:      seg = SEG_5;
      4'd6:      seg = SEG_6;
      4'd7:      seg = SEG_7;
      4'd8:      seg = SEG_8;
      4'd9:      seg = SEG_9;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: per-frame snapshot, dark guard at the start
// of each digit slot, leading-zero blanking, active-low registered pin outputs.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits_bcd,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  output logic [7:0]            seg_n,
  output logic [DIGITS-1:0]     sel_n,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [4*DIGITS-1:0] snap_bcd_reg;
  logic [DIGITS-1:0]   snap_dp_reg;
  logic [DIGITS-1:0]   blank_reg, blank_next;
  logic [DIGITS:1]     lz_run;
  logic [7:0]          seg_n_reg, seg_n_next;
  logic [DIGITS-1:0]   sel_n_reg, sel_n_next;
  logic                frame_done_reg, frame_done_next;
  logic [3:0]          cur_code;
  logic [6:0]          cur_seg;

  // Blank mask is derived from the live inputs and captured together with the snapshot.
  // lz_run[i] stays high while every digit from the top down to i is a bare zero.
  assign lz_run[DIGITS] = blank_lz;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign blank_next[gi] = (digits_bcd[4*gi +: 4] > CODE_DASH);
      end else begin : g_upper
        assign lz_run[gi] = lz_run[gi+1] & (digits_bcd[4*gi +: 4] == 4'd0) & ~dp_mask[gi];
        assign blank_next[gi] = lz_run[gi] | (digits_bcd[4*gi +: 4] > CODE_DASH);
      end
    end
  endgenerate

  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    idx_next = idx_reg;
    if (cnt_reg == CNT_W'(SCAN_DIV - 1)) begin
      cnt_next = '0;
      idx_next = (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
    end
  end

  // Outputs are computed from the upcoming cnt/idx so the registered pins line up
  // with the frame-cycle numbering.
  assign cur_code = snap_bcd_reg[{idx_next, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .code (cur_code),
    .seg  (cur_seg)
  );

  always_comb begin
    seg_n_next      = 8'hFF;
    sel_n_next      = '1;
    frame_done_next = (cnt_next == CNT_W'(SCAN_DIV - 1)) && (idx_next == IDX_W'(DIGITS - 1));
    if ((cnt_next >= CNT_W'(GUARD)) && !blank_reg[idx_next]) begin
      seg_n_next           = ~{snap_dp_reg[idx_next], cur_seg};
      sel_n_next[idx_next] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      seg_n_reg      <= 8'hFF;
      sel_n_reg      <= '1;
      frame_done_reg <= 1'b0;
      snap_bcd_reg   <= digits_bcd;
      snap_dp_reg    <= dp_mask;
      blank_reg      <= blank_next;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      seg_n_reg      <= seg_n_next;
      sel_n_reg      <= sel_n_next;
      frame_done_reg <= frame_done_next;
      // Reload at the end of the last frame cycle; the next slot 0 starts dark anyway.
      if (frame_done_reg) begin
        snap_bcd_reg <= digits_bcd;
        snap_dp_reg  <= dp_mask;
        blank_reg    <= blank_next;
      end
    end
  end

  assign seg_n      = seg_n_reg;
  assign sel_n      = sel_n_reg;
  assign frame_done = frame_done_reg;

endmodule
